// File: rtl/rom_fetch_pkg.sv
// Shared widths, limits and types for the image-ROM fetch scheduler.
// The state encoding and vector type are common to the top and its FIFO.
package rom_fetch_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;
    localparam int LANES  = 10;
    localparam int VEC_W  = LANES * DATA_W;

    localparam logic [ADDR_W-1:0] ADDR_MAX = 19'h4AFEC;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    typedef logic [VEC_W-1:0] vec_t;

endpackage

// File: rtl/rom_vec_fifo.sv
// Small synchronous FIFO holding ROM vectors plus a last-of-job flag.
// A push while full is accepted only when a pop happens on the same edge.
module rom_vec_fifo
    import rom_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_s,
    input  logic             rst_n_s,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [VEC_W-1:0] push_data_i,
    input  logic             push_last_i,
    input  logic             pop_i,
    output logic [VEC_W-1:0] head_data_o,
    output logic             head_last_o,
    output logic             head_valid_o,
    output logic [CNT_W-1:0] count_o
);

    vec_t             mem_q  [DEPTH];
    logic             last_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk_s or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]  <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q]  <= push_data_i;
                last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q         <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_data_o  = mem_q[rd_ptr_q];
    assign head_last_o  = head_valid_o && last_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/rom_fetch_sched.sv
// Issues a LANES-strided run of ROM addresses per job and streams the
// returned vectors through a small FIFO that absorbs downstream stalls.
module rom_fetch_sched
    import rom_fetch_pkg::*;
#(
    parameter int ROM_LAT    = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_s,
    input  logic              rst_n_s,
    input  logic              start_s,
    input  logic              abort_s,
    input  logic [ADDR_W-1:0] base_addr_s,
    input  logic [15:0]       num_vec_s,
    output logic              busy_s,
    output logic              done_s,
    output logic              err_s,
    output logic [ADDR_W-1:0] rom_addr_s,
    input  logic [VEC_W-1:0]  rom_d_s,
    output logic [VEC_W-1:0]  vec_data_s,
    output logic              vec_valid_s,
    input  logic              vec_ready_s,
    output logic              vec_last_s
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = ADDR_W + 20;

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [ADDR_W-1:0]  next_addr_q;
    logic [15:0]        left_q;
    logic [ROM_LAT-1:0] tag_vld_q;
    logic [ROM_LAT-1:0] tag_last_q;

    logic [CNT_W-1:0]   fifo_count;
    logic               head_last;
    logic               pop;
    logic               abort_act;
    logic               credit_ok;
    logic               issue;
    logic               issue_last;
    logic               last_accept;
    logic [SUM_W-1:0]   job_end;
    int                 inflight;

    // A pop on this edge frees a slot, so it counts as credit for a new
    // issue; without it a 2-entry FIFO could only sustain half rate.
    always_comb begin
        pop         = vec_valid_s && vec_ready_s;
        abort_act   = abort_s && (state_q != IDLE);
        inflight    = $countones(tag_vld_q);
        credit_ok   = (int'(fifo_count) + inflight - int'(pop)) < FIFO_DEPTH;
        issue       = (state_q == ISSUE) && !abort_act && credit_ok;
        issue_last  = (left_q == 16'd1);
        last_accept = pop && head_last;
        job_end     = SUM_W'(base_addr_s)
                    + (SUM_W'(num_vec_s) - SUM_W'(1)) * SUM_W'(LANES);
    end

    always_ff @(posedge clk_s or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rom_addr_q  <= '0;
            next_addr_q <= '0;
            left_q      <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        if (num_vec_s == 16'd0) begin
                            done_q <= 1'b1;
                        end else if (job_end > SUM_W'(ADDR_MAX)) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= ISSUE;
                            busy_q      <= 1'b1;
                            next_addr_q <= base_addr_s;
                            left_q      <= num_vec_s;
                        end
                    end
                end
                ISSUE: begin
                    if (abort_act) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (issue) begin
                        rom_addr_q  <= next_addr_q;
                        next_addr_q <= next_addr_q + ADDR_W'(LANES);
                        left_q      <= left_q - 16'd1;
                        if (issue_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (abort_act) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (last_accept) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Tags mirror the ROM latency; the oldest stage marks the sample edge.
    always_ff @(posedge clk_s or negedge rst_n_s) begin
        if (!rst_n_s) begin
            tag_vld_q  <= '0;
            tag_last_q <= '0;
        end else if (abort_act) begin
            tag_vld_q  <= '0;
            tag_last_q <= '0;
        end else begin
            tag_vld_q[0]  <= issue;
            tag_last_q[0] <= issue && issue_last;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
        end
    end

    rom_vec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_s        (clk_s),
        .rst_n_s      (rst_n_s),
        .flush_i      (abort_act),
        .push_i       (tag_vld_q[ROM_LAT-1] && !abort_act),
        .push_data_i  (rom_d_s),
        .push_last_i  (tag_last_q[ROM_LAT-1]),
        .pop_i        (pop),
        .head_data_o  (vec_data_s),
        .head_last_o  (head_last),
        .head_valid_o (vec_valid_s),
        .count_o      (fifo_count)
    );

    assign busy_s     = busy_q;
    assign done_s     = done_q;
    assign err_s      = err_q;
    assign rom_addr_s = rom_addr_q;
    assign vec_last_s = head_last;

endmodule

// File: tb/tb_rom_fetch_sched.sv
// Self-checking bench for rom_fetch_sched: table-driven jobs, hand-written
// corner sequences and random jobs scored against an address-level model.
module tb_rom_fetch_sched;

   localparam int K_RUN  = 0;
   localparam int K_DONE = 1;
   localparam int K_ERR  = 2;
   localparam longint IMG_MAX = 64'h4AFEC;

   typedef logic [159:0] tvec_t;

   typedef struct {
      logic [18:0] base;
      logic [15:0] num;
      int          mode;
      bit          midStart;
      bit          withAbort;
      int          kind;
   } job_rec_t;

   logic        clk_s = 1'b0;
   logic        rst_n_s = 1'b0;
   logic        start_s = 1'b0;
   logic        abort_s = 1'b0;
   logic [18:0] base_addr_s = '0;
   logic [15:0] num_vec_s = '0;
   logic        busy_s;
   logic        done_s;
   logic        err_s;
   logic [18:0] rom_addr_s;
   tvec_t       rom_d_s;
   tvec_t       vec_data_s;
   logic        vec_valid_s;
   logic        vec_ready_s = 1'b0;
   logic        vec_last_s;

   int checks = 0;
   int errors = 0;

   rom_fetch_sched dut (
      .clk_s       (clk_s),
      .rst_n_s     (rst_n_s),
      .start_s     (start_s),
      .abort_s     (abort_s),
      .base_addr_s (base_addr_s),
      .num_vec_s   (num_vec_s),
      .busy_s      (busy_s),
      .done_s      (done_s),
      .err_s       (err_s),
      .rom_addr_s  (rom_addr_s),
      .rom_d_s     (rom_d_s),
      .vec_data_s  (vec_data_s),
      .vec_valid_s (vec_valid_s),
      .vec_ready_s (vec_ready_s),
      .vec_last_s  (vec_last_s)
   );

   // Clock generation: 10 ns period, outputs sampled on the falling edge.
   always #5 clk_s = ~clk_s;

   // Image ROM model: every lane of every address gets a distinct word.
   function automatic tvec_t romFn(input logic [18:0] a);
      tvec_t v;
      logic [31:0] t;
      v = '0;
      for (int k = 0; k < 10; k++) begin
         t = {13'b0, a} * 32'd3 + k * 32'd241 + ({13'b0, a} >> 7) + 32'h5A00;
         v[k*16 +: 16] = t[15:0];
      end
      return v;
   endfunction

   assign rom_d_s = romFn(rom_addr_s);

   // Outcome of a job request computed directly from the job's address span.
   function automatic int expectKind(input logic [18:0] b, input logic [15:0] n);
      longint lastAddr;
      if (n == 16'd0) return K_DONE;
      lastAddr = longint'(b) + (longint'(n) - 1) * 10;
      return (lastAddr > IMG_MAX) ? K_ERR : K_RUN;
   endfunction

   task automatic checkOutput(input string name, input tvec_t act, input tvec_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"},  busy_s, 0);
      checkOutput({tag, "_done"},  done_s, 0);
      checkOutput({tag, "_err"},   err_s, 0);
      checkOutput({tag, "_addr"},  rom_addr_s, 0);
      checkOutput({tag, "_valid"}, vec_valid_s, 0);
      checkOutput({tag, "_last"},  vec_last_s, 0);
      checkOutput({tag, "_data"},  vec_data_s, 0);
   endtask

   // Runs one job and scores every accepted vector against the model queue.
   task automatic applyStimulus(input logic [18:0] b, input logic [15:0] n,
                                input int mode, input bit midStart,
                                input bit withAbort, input int kind);
      tvec_t       expData[$];
      bit          expLast[$];
      logic [18:0] prevAddr;
      int          cyc;
      bit          gotLast;
      bit          stalled;
      tvec_t       stallData;
      logic        stallLast;
      bit          rdy;
      bit          lastExp;

      if (kind == K_RUN) begin
         for (int i = 0; i < int'(n); i++) begin
            expData.push_back(romFn(19'(int'(b) + i * 10)));
            expLast.push_back(i == int'(n) - 1);
         end
      end

      @(negedge clk_s);
      base_addr_s = b;
      num_vec_s   = n;
      start_s     = 1'b1;
      abort_s     = withAbort;
      prevAddr    = rom_addr_s;
      @(negedge clk_s);
      start_s = 1'b0;
      abort_s = 1'b0;

      if (kind != K_RUN) begin
         checkOutput("resp_done",  done_s, kind == K_DONE);
         checkOutput("resp_err",   err_s,  kind == K_ERR);
         checkOutput("resp_busy",  busy_s, 0);
         checkOutput("resp_addr",  rom_addr_s, prevAddr);
         checkOutput("resp_valid", vec_valid_s, 0);
         @(negedge clk_s);
         checkOutput("resp_pulse_done", done_s, 0);
         checkOutput("resp_pulse_err",  err_s, 0);
         checkOutput("resp_busy2",      busy_s, 0);
         checkOutput("resp_addr2",      rom_addr_s, prevAddr);
         return;
      end

      checkOutput("job_busy", busy_s, 1);
      cyc = 0;
      gotLast = 0;
      stalled = 0;
      stallData = '0;
      stallLast = 1'b0;
      while (!gotLast && cyc < 3000) begin
         if (stalled) begin
            checkOutput("stall_valid", vec_valid_s, 1);
            checkOutput("stall_data",  vec_data_s, stallData);
            checkOutput("stall_last",  vec_last_s, stallLast);
         end
         checkOutput("job_no_done", done_s, 0);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         vec_ready_s = rdy;
         if (midStart && cyc == 2) begin
            start_s     = 1'b1;
            base_addr_s = 19'h07777;
            num_vec_s   = 16'd5;
         end else begin
            start_s = 1'b0;
         end
         if (vec_valid_s && rdy) begin
            if (expData.size() == 0) begin
               checkOutput("extra_vector", 1, 0);
               gotLast = 1;
            end else begin
               lastExp = expLast.pop_front();
               checkOutput("vec_data", vec_data_s, expData.pop_front());
               checkOutput("vec_last", vec_last_s, lastExp);
               if (lastExp) gotLast = 1;
            end
         end
         stalled   = vec_valid_s && !rdy;
         stallData = vec_data_s;
         stallLast = vec_last_s;
         cyc++;
         @(negedge clk_s);
      end
      start_s = 1'b0;
      checkOutput("job_timeout", gotLast, 1);
      checkOutput("end_done",  done_s, 1);
      checkOutput("end_busy",  busy_s, 0);
      checkOutput("end_valid", vec_valid_s, 0);
      @(negedge clk_s);
      checkOutput("end_pulse", done_s, 0);
   endtask

   job_rec_t tbl[9];

   initial begin
      logic [18:0] lastAddr;
      logic [18:0] addrVal[$];
      int          addrCyc[$];
      int          accCyc[$];
      int          doneCnt;
      int          doneCyc;
      int          idx;
      logic [18:0] rb;
      logic [15:0] rn;

      tbl[0] = '{19'h04AFD8, 16'd3,      0, 1'b0, 1'b0, K_RUN};
      tbl[1] = '{19'h04AFD8, 16'd4,      0, 1'b0, 1'b0, K_ERR};
      tbl[2] = '{19'h000200, 16'd8,      1, 1'b0, 1'b0, K_RUN};
      tbl[3] = '{19'h000300, 16'd0,      0, 1'b0, 1'b0, K_DONE};
      tbl[4] = '{19'h000400, 16'd6,      2, 1'b1, 1'b0, K_RUN};
      tbl[5] = '{19'h000500, 16'd2,      0, 1'b0, 1'b1, K_RUN};
      tbl[6] = '{19'h04AFEC, 16'd1,      2, 1'b0, 1'b0, K_RUN};
      tbl[7] = '{19'h04AFED, 16'd1,      0, 1'b0, 1'b0, K_ERR};
      tbl[8] = '{19'h000000, 16'hFFFF,   0, 1'b0, 1'b0, K_ERR};

      rst_n_s = 1'b0;
      repeat (3) @(negedge clk_s);
      checkAllZero("reset");
      rst_n_s = 1'b1;
      @(negedge clk_s);
      checkAllZero("idle");

      applyStimulus(19'd100, 16'd1, 0, 1'b0, 1'b0, K_RUN);

      // Back-to-back sequence from base 0: strided addresses, burst, done.
      doneCnt = 0;
      doneCyc = -1;
      lastAddr = rom_addr_s;
      base_addr_s = 19'd0;
      num_vec_s   = 16'd3;
      start_s     = 1'b1;
      vec_ready_s = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk_s);
         start_s = 1'b0;
         if (rom_addr_s !== lastAddr) begin
            addrVal.push_back(rom_addr_s);
            addrCyc.push_back(k);
            lastAddr = rom_addr_s;
         end
         if (done_s) begin
            doneCnt++;
            doneCyc = k;
         end
         if (vec_valid_s && vec_ready_s) begin
            idx = accCyc.size();
            checkOutput("seq3_data", vec_data_s, romFn(19'(idx * 10)));
            checkOutput("seq3_last", vec_last_s, idx == 2);
            accCyc.push_back(k);
         end
      end
      checkOutput("seq3_naddr", addrVal.size(), 3);
      if (addrVal.size() == 3) begin
         checkOutput("seq3_addr0", addrVal[0], 0);
         checkOutput("seq3_addr1", addrVal[1], 10);
         checkOutput("seq3_addr2", addrVal[2], 20);
         checkOutput("seq3_addr_gap", addrCyc[2] - addrCyc[0], 2);
      end
      checkOutput("seq3_nacc", accCyc.size(), 3);
      if (accCyc.size() == 3) begin
         checkOutput("seq3_b2b", accCyc[2] - accCyc[0], 2);
         checkOutput("seq3_done_cyc", doneCyc, accCyc[2] + 1);
      end
      checkOutput("seq3_done_cnt", doneCnt, 1);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(tbl[i].base, tbl[i].num, tbl[i].mode,
                       tbl[i].midStart, tbl[i].withAbort, tbl[i].kind);
      end

      // Abort in the middle of a long job, then a clean job right after.
      @(negedge clk_s);
      base_addr_s = 19'h01000;
      num_vec_s   = 16'd100;
      start_s     = 1'b1;
      vec_ready_s = 1'b1;
      @(negedge clk_s);
      start_s = 1'b0;
      repeat (8) @(negedge clk_s);
      checkOutput("abort_pre_valid", vec_valid_s, 1);
      checkOutput("abort_pre_busy",  busy_s, 1);
      abort_s     = 1'b1;
      vec_ready_s = 1'b0;
      @(negedge clk_s);
      abort_s = 1'b0;
      checkOutput("abort_valid", vec_valid_s, 0);
      checkOutput("abort_busy",  busy_s, 0);
      checkOutput("abort_done",  done_s, 0);
      checkOutput("abort_last",  vec_last_s, 0);
      @(negedge clk_s);
      checkOutput("abort_done2",  done_s, 0);
      checkOutput("abort_valid2", vec_valid_s, 0);
      vec_ready_s = 1'b1;
      applyStimulus(19'h02000, 16'd4, 0, 1'b0, 1'b0, K_RUN);

      // Asynchronous reset while the FIFO is full and stalled.
      @(negedge clk_s);
      base_addr_s = 19'h03000;
      num_vec_s   = 16'd50;
      start_s     = 1'b1;
      vec_ready_s = 1'b0;
      @(negedge clk_s);
      start_s = 1'b0;
      repeat (5) @(negedge clk_s);
      checkOutput("rst_pre_busy",  busy_s, 1);
      checkOutput("rst_pre_valid", vec_valid_s, 1);
      @(posedge clk_s);
      #2 rst_n_s = 1'b0;
      #1 checkAllZero("async_rst");
      repeat (2) @(negedge clk_s);
      rst_n_s = 1'b1;
      vec_ready_s = 1'b1;
      @(negedge clk_s);
      checkAllZero("post_rst");
      @(negedge clk_s);
      checkOutput("post_rst_done", done_s, 0);
      checkOutput("post_rst_busy", busy_s, 0);

      // Random jobs, biased towards the end of the image.
      for (int j = 0; j < 30; j++) begin
         if ($urandom_range(0, 3) == 0) begin
            rb = 19'(int'(IMG_MAX) - int'($urandom_range(0, 150)));
         end else begin
            rb = 19'($urandom_range(0, 32'h4AFEC));
         end
         rn = 16'($urandom_range(0, 12));
         applyStimulus(rb, rn, 2, 1'($urandom_range(0, 1)), 1'b0,
                       expectKind(rb, rn));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends on its own.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
